// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter scheduler: state encoding, default sizing
// and the channel-index width helper.
package counter_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_CLEAR = ST_CLEAR,
    S_RUN   = ST_RUN,
    S_DONE  = ST_DONE
  } state_e;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_NUM_CH = 2;

  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_count_unit.sv
// One channel of the scheduler: a WIDTH-bit up-counter with clear priority
// over increment.
module sched_count_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_scheduler.sv
// Sequencing controller: clears a bank of counters, then runs each one in turn
// from 0 up to its latched limit, lowest channel first, and pulses done.
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        pause,
  input  logic [NUM_CH*WIDTH-1:0]     limit,
  output logic [NUM_CH-1:0]           enable,
  output logic [NUM_CH*WIDTH-1:0]     counter_out,
  output logic [ch_idx_w(NUM_CH)-1:0] active_ch,
  output logic                        busy,
  output logic                        done
);

  localparam int CH_W = ch_idx_w(NUM_CH);

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           act_q, act_d;
  logic [NUM_CH*WIDTH-1:0]   lim_q, lim_d;
  logic [WIDTH-1:0]          cnt [NUM_CH];
  logic [WIDTH-1:0]          cur_cnt;
  logic [WIDTH-1:0]          cur_lim;
  logic                      clr;

  assign clr = (state_q == S_CLEAR);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sched_count_unit #(.WIDTH(WIDTH)) u_cnt (
      .clock (clock),
      .reset (reset),
      .clear (clr),
      .inc   (enable[g]),
      .count (cnt[g])
    );
    assign counter_out[g*WIDTH +: WIDTH] = cnt[g];
  end

  // Select the count and latched limit of the channel that owns the sequence.
  always_comb begin
    cur_cnt = '0;
    cur_lim = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (act_q == CH_W'(c)) begin
        cur_cnt = cnt[c];
        cur_lim = lim_q[c*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    lim_d   = lim_q;
    enable  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        act_d = '0;
        if (start) begin
          lim_d   = limit;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy    = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (!pause) begin
          if (cur_cnt != cur_lim) begin
            enable = NUM_CH'(1) << act_q;
          end else if (act_q == CH_W'(NUM_CH - 1)) begin
            state_d = S_DONE;
          end else begin
            act_d = act_q + CH_W'(1);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        act_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      act_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      lim_q   <= lim_d;
    end
  end

  assign active_ch = act_q;

endmodule
